// File: rtl/mac_sequencer.sv
// Control FSM for the MAC datapath: clear, fetch/multiply/accumulate per term, done pulse.
// Optional FETCH timeout with sticky err is enabled by defining MAC_SEQ_TIMEOUT_EN.
module mac_sequencer #(
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned TO_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             op_ack,
    input  logic             acc_carry,
    output logic             op_req,
    output logic [LEN_W-1:0] idx,
    output logic             mul_en,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_MUL, S_ACC, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic             last_term_c;
    logic             timeout_c;
    logic             op_req_d, mul_en_d, acc_en_d, acc_clr_d, busy_d, done_d;

    assign last_term_c = (idx == (len_q - LEN_W'(1)));

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    logic [TO_W-1:0] to_cnt_q;

    assign timeout_c = (state_q == S_FETCH) && !op_ack && (to_cnt_q == TO_W'(TO_CYC - 1));

    // Counts consecutive unacknowledged FETCH cycles; idle at zero outside FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  to_cnt_q <= '0;
        else if (state_q != S_FETCH) to_cnt_q <= '0;
        else if (!op_ack)            to_cnt_q <= to_cnt_q + TO_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  err <= 1'b0;
        else if (state_d == S_CLEAR) err <= 1'b0;
        else if (timeout_c)          err <= 1'b1;
    end
`else
    assign timeout_c = 1'b0;
    assign err       = 1'b0;

    // TO_CYC only matters when the timeout is built in.
    if (TO_CYC == 0) begin : g_to_cyc_unused
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = (len_q == '0) ? S_DONE : S_FETCH;
            S_FETCH: begin
                if (op_ack)         state_d = S_MUL;
                else if (timeout_c) state_d = S_DONE;
            end
            S_MUL:   state_d = S_ACC;
            S_ACC:   state_d = last_term_c ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Decode from the next state so the registered strobes line up with state occupancy.
    always_comb begin
        op_req_d  = 1'b0;
        mul_en_d  = 1'b0;
        acc_en_d  = 1'b0;
        acc_clr_d = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != S_IDLE);
        case (state_d)
            S_CLEAR: acc_clr_d = 1'b1;
            S_FETCH: op_req_d  = 1'b1;
            S_MUL:   mul_en_d  = 1'b1;
            S_ACC:   acc_en_d  = 1'b1;
            S_DONE:  done_d    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_req  <= 1'b0;
            mul_en  <= 1'b0;
            acc_en  <= 1'b0;
            acc_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            op_req  <= op_req_d;
            mul_en  <= mul_en_d;
            acc_en  <= acc_en_d;
            acc_clr <= acc_clr_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Job length, term index and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
            idx   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                len_q <= len;
                idx   <= '0;
            end else if (state_q == S_ACC && !last_term_c) begin
                idx <= idx + LEN_W'(1);
            end
            if (state_d == S_CLEAR)                  ovf <= 1'b0;
            else if (state_q == S_ACC && acc_carry) ovf <= 1'b1;
        end
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control FSM for the MAC datapath: on `start`, it runs a dot product of `len` terms by clearing the accumulator register, fetching each operand pair through a request/acknowledge handshake, strobing the product stage and then the accumulate stage. It drives the enable and clear pins of the 8-bit accumulator register and the product register, and monitors the 8-bit adder's carry-out for overflow. It sits between the operand source (memory or host) and the multiplier/adder/register datapath.

## Interface
- `LEN_W`, 4: width of `len` and `idx`; the maximum term count is 2^LEN_W-1.
- `TO_CYC`, 16: cycles in FETCH without `op_ack` before timeout (used only with the macro).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  begin a job; sampled only in IDLE.
- `len`  in  LEN_W  number of terms; latched when `start` is accepted.
- `op_ack`  in  1  source has valid operands this cycle; sampled only in FETCH.
- `acc_carry`  in  1  carry-out of the accumulator adder.
- `op_req`  out  1  operand request.
- `idx`  out  LEN_W  index of the current term.
- `mul_en`  out  1  load enable for the product register.
- `acc_en`  out  1  load enable for the accumulator register.
- `acc_clr`  out  1  synchronous clear for the accumulator register.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse when the job ends.
- `ovf`  out  1  sticky accumulate overflow.
- `err`  out  1  sticky timeout flag.

## Operation
- All outputs are registered Moore outputs decoded from the state.
- States are IDLE, CLEAR, FETCH, MUL, ACC and DONE.
- **IDLE**
  - All strobes are 0 and `busy`=0.
  - `start`=1 latches `len`, sets `idx`=0 and moves to CLEAR.
- **CLEAR**
  - `acc_clr`=1 for one cycle; `ovf` and `err` clear.
  - If latched len=0, go to DONE; otherwise go to FETCH.
- **FETCH**
  - `op_req`=1 and the FSM holds until `op_ack`=1 is sampled, then goes to MUL.
- **MUL**
  - `mul_en`=1 for one cycle, then go to ACC.
- **ACC**
  - `acc_en`=1 for one cycle.
  - If `acc_carry`=1 this cycle, `ovf` sets.
  - If `idx`==len-1, go to DONE; otherwise increment `idx` and go to FETCH.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored. `op_ack` outside FETCH is ignored.
- `ovf` and `err` hold their values through IDLE until the next CLEAR.
- `idx` never wraps. The maximum len of 2^LEN_W-1 ends at `idx`=2^LEN_W-2.

## Timing
- Reset (`reset`=0) is asynchronous.
  - State goes to IDLE; every output, `idx`, the latched len and the timeout counter go to 0.
  - Reset applied mid-job aborts the job; no `done` pulse follows.
- Let edge 0 be the edge that samples `start`. With `op_ack` held at 1:
  - CLEAR occupies cycle 1.
  - Term i occupies cycles 2+3i (FETCH), 3+3i (MUL) and 4+3i (ACC).
  - `done` is high in cycle 2+3·len.
  - For len=0, `done` is high in cycle 2.
- Each cycle of `op_ack` stall adds one cycle to the job.
- A new `start` is accepted at the earliest on the edge after DONE, i.e. in the cycle IDLE is occupied.

## Configuration
- `MAC_SEQ_TIMEOUT_EN` defined:
  - A counter runs while in FETCH and resets on entry to FETCH.
  - After `TO_CYC` consecutive FETCH cycles without `op_ack`, the FSM goes to DONE and sets `err`=1.
  - No further `acc_en` is issued for that job.
- Not defined:
  - FETCH waits indefinitely.
  - `err` is tied to 0 and the counter logic is absent.

## Test plan
- Reset values: hold `reset`=0 with random inputs -> every output 0. Release `reset`, pulse `start` with len=0 -> `acc_clr` in cycle 1, `done` in cycle 2, and `mul_en` and `acc_en` never assert.
- len=3 with `op_ack` tied to 1 -> `acc_clr` in cycle 1; `acc_en` in cycles 4, 7 and 10 with `idx`=0, 1, 2; `done` in cycle 11; `busy` high in cycles 1–11.
- len=2, `op_ack` withheld for 5 cycles on term 1 -> `op_req` is held, `done` arrives in cycle 13, and exactly two `acc_en` pulses occur.
- len=4 with `acc_carry`=1 during the second `acc_en` -> `ovf`=1 from then until the next `start`; the next job's CLEAR returns it to 0.
- Robustness:
  - Pulse `start` during FETCH -> ignored.
  - Drive `reset`=0 mid-job in MUL -> all outputs 0 immediately, with no `done` pulse.
  - A fresh `start` afterwards runs normally.
- Timeout, with `MAC_SEQ_TIMEOUT_EN` defined: len=2, `op_ack` never asserts -> `done` appears 16 FETCH cycles later with `err`=1 and zero `acc_en` pulses. Without the macro, the same stimulus leaves `busy` high indefinitely.
